membus_n_connect: RTL and testbench

//  Parametrised 1-master / NSLV-slave PDP-6 memory bus connector, successor to the fixed 2-slave wired-OR fan-out.

---
 rtl/membus_n_connect_if.sv | 43 ++++
 rtl/membus_n_connect.sv | 125 ++++++++++++
 tb/tb_membus_n_connect.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/membus_n_connect_if.sv
// PDP-6 memory bus bundle: one master-side port plus NSLV packed slave ports.
// The connector sits on the slave modport; the processor and memories sit on master.
interface membus_n_connect_if #(
  parameter int NSLV = 4
);
  logic                      m_wr_rs;
  logic                      m_rq_cyc;
  logic                      m_rd_rq;
  logic                      m_wr_rq;
  logic [14:0]               m_ma;
  logic [3:0]                m_sel;
  logic                      m_fmc_select;
  logic [35:0]               m_mb_write;
  logic                      m_addr_ack;
  logic                      m_rd_rs;
  logic [35:0]               m_mb_read;

  logic [NSLV-1:0]           s_wr_rs;
  logic [NSLV-1:0]           s_rq_cyc;
  logic [NSLV-1:0]           s_rd_rq;
  logic [NSLV-1:0]           s_wr_rq;
  logic [NSLV-1:0]           s_fmc_select;
  logic [NSLV-1:0][14:0]     s_ma;
  logic [NSLV-1:0][3:0]      s_sel;
  logic [NSLV-1:0][35:0]     s_mb_write;
  logic [NSLV-1:0]           s_addr_ack;
  logic [NSLV-1:0]           s_rd_rs;
  logic [NSLV-1:0][35:0]     s_mb_read;

  modport slave (
    input  m_wr_rs, m_rq_cyc, m_rd_rq, m_wr_rq, m_ma, m_sel, m_fmc_select, m_mb_write,
    output m_addr_ack, m_rd_rs, m_mb_read,
    output s_wr_rs, s_rq_cyc, s_rd_rq, s_wr_rq, s_fmc_select, s_ma, s_sel, s_mb_write,
    input  s_addr_ack, s_rd_rs, s_mb_read
  );

  modport master (
    output m_wr_rs, m_rq_cyc, m_rd_rq, m_wr_rq, m_ma, m_sel, m_fmc_select, m_mb_write,
    input  m_addr_ack, m_rd_rs, m_mb_read,
    input  s_wr_rs, s_rq_cyc, s_rd_rq, s_wr_rq, s_fmc_select, s_ma, s_sel, s_mb_write,
    output s_addr_ack, s_rd_rs, s_mb_read
  );
endinterface

// File: rtl/membus_n_connect.sv
// 1-master / NSLV-slave memory bus connector: broadcast until the first addr_ack,
// then lock the cycle to that slave; NXM timeout and sticky multi-ack conflict flag.
module membus_n_connect #(
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 1000,
  parameter int TOW     = 10
) (
  input  logic                clk,
  input  logic                reset,
  membus_n_connect_if.slave   bus,
  output logic [NSLV-1:0]     owner,
  output logic                busy,
  output logic                nxm,
  output logic                conflict,
  input  logic                conflict_clr
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_OWNED, ST_NXM} state_t;

  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  state_t          r_state, w_state_nx;
  logic [NSLV-1:0] r_owner, w_owner_nx;
  logic [TOW-1:0]  r_timer, w_timer_nx;
  logic            r_nxm, w_nxm_nx;
  logic            r_conflict, w_conflict_nx;
  logic [NSLV-1:0] w_ack_low, w_en;
  logic            w_bcast, w_multi;
  logic [35:0]     w_data;

  // isolate the lowest set ack bit so the lowest-index slave wins
  assign w_ack_low = bus.s_addr_ack & (~bus.s_addr_ack + NSLV'(1));
  assign w_multi   = $countones(bus.s_addr_ack) > 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_timer    <= '0;
      r_nxm      <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_owner    <= w_owner_nx;
      r_timer    <= w_timer_nx;
      r_nxm      <= w_nxm_nx;
      r_conflict <= w_conflict_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_timer_nx = r_timer;
    w_nxm_nx   = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.m_rq_cyc) begin
        w_state_nx = ST_WAIT;
        w_timer_nx = '0;
      end
      ST_WAIT: begin
        // request drop beats ack, ack beats timeout
        if (!bus.m_rq_cyc) begin
          w_state_nx = ST_IDLE;
        end else if (|bus.s_addr_ack) begin
          w_state_nx = ST_OWNED;
          w_owner_nx = w_ack_low;
        end else if (r_timer == TO_LAST) begin
          w_state_nx = ST_NXM;
          w_nxm_nx   = 1'b1;
        end else if (r_timer != '1) begin
          w_timer_nx = r_timer + 1'b1;
        end
      end
      ST_OWNED: if (!bus.m_rq_cyc) begin
        w_state_nx = ST_IDLE;
        w_owner_nx = '0;
      end
      ST_NXM: if (!bus.m_rq_cyc) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    w_conflict_nx = r_conflict;
    if (r_state == ST_WAIT && w_multi) w_conflict_nx = 1'b1;
    else if (conflict_clr)             w_conflict_nx = 1'b0;
  end

  assign w_bcast = (r_state == ST_IDLE) || (r_state == ST_WAIT);
  assign w_en    = w_bcast ? '1 : ((r_state == ST_OWNED) ? r_owner : '0);

  // wired-OR data path restricted to enabled slaves; NXM enables none
  always_comb begin
    w_data = bus.m_mb_write;
    for (int i = 0; i < NSLV; i++)
      if (w_en[i]) w_data = w_data | bus.s_mb_read[i];
  end

  always_comb begin
    bus.s_wr_rs      = w_en & {NSLV{bus.m_wr_rs}};
    bus.s_rq_cyc     = w_en & {NSLV{bus.m_rq_cyc}};
    bus.s_rd_rq      = w_en & {NSLV{bus.m_rd_rq}};
    bus.s_wr_rq      = w_en & {NSLV{bus.m_wr_rq}};
    bus.s_fmc_select = w_en & {NSLV{bus.m_fmc_select}};
    bus.s_ma         = '0;
    bus.s_sel        = '0;
    bus.s_mb_write   = '0;
    for (int i = 0; i < NSLV; i++) begin
      bus.s_ma[i]       = {15{w_en[i]}} & bus.m_ma;
      bus.s_sel[i]      = {4{w_en[i]}}  & bus.m_sel;
      bus.s_mb_write[i] = {36{w_en[i]}} & w_data;
    end
  end

  assign bus.m_addr_ack = |(bus.s_addr_ack & w_en);
  assign bus.m_rd_rs    = |(bus.s_rd_rs & w_en);
  assign bus.m_mb_read  = w_data;

  assign owner    = r_owner;
  assign busy     = (r_state != ST_IDLE);
  assign nxm      = r_nxm;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_membus_n_connect.sv
// Scoreboard bench for membus_n_connect: directed scenarios then random traffic,
// expected outputs from a transaction-level model queued and checked by a monitor.
module tb_membus_n_connect;
  localparam int NSLV = 4, TIMEOUT = 8, TOW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            conflict_clr = 1'b0;
  logic [NSLV-1:0] owner;
  logic            busy, nxm, conflict;

  membus_n_connect_if #(.NSLV(NSLV)) bus();

  membus_n_connect #(.NSLV(NSLV), .TIMEOUT(TIMEOUT), .TOW(TOW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .owner(owner), .busy(busy),
    .nxm(nxm), .conflict(conflict), .conflict_clr(conflict_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 ack, rdrs;
    logic [35:0]          rd;
    logic [NSLV-1:0]      wrs, rq, rdq, wrq, fmc;
    logic [NSLV*15-1:0]   ma;
    logic [NSLV*4-1:0]    sel;
    logic [NSLV*36-1:0]   mbw;
    logic [NSLV-1:0]      own;
    logic                 busy, nxm, conf;
  } exp_t;

  exp_t sbq[$];
  int   total = 0, bad = 0;

  // model: who owns the cycle (-1 none), whether we are waiting and for how long
  int  md_own = -1, md_waited = 0;
  bit  md_wait = 0, md_nxst = 0, md_nxm = 0, md_conf = 0;

  bit          dir_en = 0;
  logic [35:0] dir_mbw = '0;
  logic [35:0] dir_rd [NSLV];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    logic [NSLV-1:0] a;
    bit rq;
    a  = bus.s_addr_ack;
    rq = bus.m_rq_cyc;
    if (reset) begin
      md_own = -1; md_wait = 0; md_nxst = 0; md_nxm = 0; md_conf = 0; md_waited = 0;
      return;
    end
    if (md_wait && $countones(a) >= 2) md_conf = 1;
    else if (conflict_clr)             md_conf = 0;
    md_nxm = 0;
    if (md_wait) begin
      if (!rq) md_wait = 0;
      else if (a != 0) begin
        md_wait = 0;
        for (int i = NSLV-1; i >= 0; i--) if (a[i]) md_own = i;
      end else if (md_waited == TIMEOUT-1) begin
        md_wait = 0; md_nxst = 1; md_nxm = 1;
      end else md_waited++;
    end else if (md_own >= 0) begin
      if (!rq) md_own = -1;
    end else if (md_nxst) begin
      if (!rq) md_nxst = 0;
    end else if (rq) begin
      md_wait = 1; md_waited = 0;
    end
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit bc;
    logic [NSLV-1:0] g;
    bc = !md_nxst && md_own < 0;
    e.rd = bus.m_mb_write; e.ack = 0; e.rdrs = 0;
    if (bc) begin
      e.ack  = |bus.s_addr_ack;
      e.rdrs = |bus.s_rd_rs;
      for (int i = 0; i < NSLV; i++) e.rd = e.rd | bus.s_mb_read[i];
    end else if (md_own >= 0) begin
      e.ack  = bus.s_addr_ack[md_own];
      e.rdrs = bus.s_rd_rs[md_own];
      e.rd   = e.rd | bus.s_mb_read[md_own];
    end
    for (int i = 0; i < NSLV; i++) g[i] = bc || (md_own == i);
    e.wrs = g & {NSLV{bus.m_wr_rs}};
    e.rq  = g & {NSLV{bus.m_rq_cyc}};
    e.rdq = g & {NSLV{bus.m_rd_rq}};
    e.wrq = g & {NSLV{bus.m_wr_rq}};
    e.fmc = g & {NSLV{bus.m_fmc_select}};
    for (int i = 0; i < NSLV; i++) begin
      e.ma[i*15 +: 15] = g[i] ? bus.m_ma : 15'd0;
      e.sel[i*4 +: 4]  = g[i] ? bus.m_sel : 4'd0;
      e.mbw[i*36 +: 36] = g[i] ? e.rd : 36'd0;
    end
    e.own  = (md_own >= 0) ? NSLV'(1 << md_own) : '0;
    e.busy = md_wait || md_own >= 0 || md_nxst;
    e.nxm  = md_nxm;
    e.conf = md_conf;
    return e;
  endfunction

  task automatic step(input bit rst, input bit rq, input logic [NSLV-1:0] ack,
                      input logic [NSLV-1:0] rdrs, input bit clr);
    logic [63:0] r;
    @(posedge clk);
    model_edge();
    #1;
    reset = rst; bus.m_rq_cyc = rq; bus.s_addr_ack = ack; bus.s_rd_rs = rdrs;
    conflict_clr = clr;
    r = {$urandom, $urandom};
    bus.m_wr_rs = r[0]; bus.m_rd_rq = r[1]; bus.m_wr_rq = r[2]; bus.m_fmc_select = r[3];
    bus.m_ma = r[18:4]; bus.m_sel = r[22:19];
    if (dir_en) begin
      bus.m_mb_write = dir_mbw;
      for (int i = 0; i < NSLV; i++) bus.s_mb_read[i] = dir_rd[i];
    end else begin
      r = {$urandom, $urandom}; bus.m_mb_write = r[35:0];
      for (int i = 0; i < NSLV; i++) begin
        r = {$urandom, $urandom};
        bus.s_mb_read[i] = (r[63:60] == 0) ? r[35:0] : 36'd0;
      end
    end
    #1;
    sbq.push_back(expect_now());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("m_addr_ack", bus.m_addr_ack, e.ack);
        chk("m_rd_rs",    bus.m_rd_rs,    e.rdrs);
        chk("m_mb_read",  bus.m_mb_read,  e.rd);
        chk("s_wr_rs",    bus.s_wr_rs,    e.wrs);
        chk("s_rq_cyc",   bus.s_rq_cyc,   e.rq);
        chk("s_rd_rq",    bus.s_rd_rq,    e.rdq);
        chk("s_wr_rq",    bus.s_wr_rq,    e.wrq);
        chk("s_fmc",      bus.s_fmc_select, e.fmc);
        chk("s_ma",       bus.s_ma,       e.ma);
        chk("s_sel",      bus.s_sel,      e.sel);
        chk("s_mb_write", bus.s_mb_write, e.mbw);
        chk("owner",      owner,          e.own);
        chk("busy",       busy,           e.busy);
        chk("nxm",        nxm,            e.nxm);
        chk("conflict",   conflict,       e.conf);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    bus.m_rq_cyc = 0; bus.m_wr_rs = 0; bus.m_rd_rq = 0; bus.m_wr_rq = 0;
    bus.m_ma = '0; bus.m_sel = '0; bus.m_fmc_select = 0; bus.m_mb_write = '0;
    bus.s_addr_ack = '0; bus.s_rd_rs = '0; bus.s_mb_read = '0;
    for (int i = 0; i < NSLV; i++) dir_rd[i] = '0;

    // reset, then lock onto slave 2
    step(1, 0, 4'b0000, 4'b0000, 0);
    step(0, 0, 4'b0000, 4'b0000, 0);
    #1;
    chk("rst_owner", owner, 4'b0000); chk("rst_busy", busy, 0);
    chk("rst_nxm", nxm, 0); chk("rst_conf", conflict, 0);
    step(0, 1, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b0100, 4'b0000, 0);
    #1; chk("t1_bcast_ack", bus.m_addr_ack, 1);
    step(0, 1, 4'b0100, 4'b0000, 0);
    #1;
    chk("t1_owner", owner, 4'b0100); chk("t1_ack", bus.m_addr_ack, 1);
    chk("t1_srq", bus.s_rq_cyc, 4'b0100);

    // owned read from slave 2 while the others drive garbage
    dir_en = 1; dir_mbw = '0;
    for (int i = 0; i < NSLV; i++) dir_rd[i] = 36'o777;
    dir_rd[2] = 36'o123456701234;
    step(0, 1, 4'b0000, 4'b0100, 0);
    #1; chk("t2_rd", bus.m_mb_read, 36'o123456701234); chk("t2_rdrs1", bus.m_rd_rs, 1);
    step(0, 1, 4'b0000, 4'b1011, 0);
    #1; chk("t2_rdrs0", bus.m_rd_rs, 0);
    dir_en = 0;
    step(0, 0, 4'b0000, 4'b0000, 0);

    // NXM: pulse exactly TIMEOUT cycles after entering WAIT_ACK
    step(0, 1, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < TIMEOUT; k++) begin
      step(0, 1, 4'b0000, 4'b0000, 0);
      #1; chk("t3_nxm_early", nxm, 0);
    end
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t3_nxm_pulse", nxm, 1); chk("t3_srq0", bus.s_rq_cyc, 4'b0000);
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t3_nxm_once", nxm, 0); chk("t3_busy", busy, 1);
    step(0, 0, 4'b0000, 4'b0000, 0);
    step(0, 0, 4'b0000, 4'b0000, 0);
    #1; chk("t3_idle", busy, 0);

    // multi-ack conflict, clear, and set-beats-clear
    step(0, 1, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b1010, 4'b0000, 0);
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t4_owner", owner, 4'b0010); chk("t4_conf", conflict, 1);
    step(0, 1, 4'b0000, 4'b0000, 1);
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t4_clr", conflict, 0);
    step(0, 0, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b0011, 4'b0000, 1);
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t4_setwins", conflict, 1); chk("t4_owner2", owner, 4'b0001);
    step(0, 0, 4'b0000, 4'b0000, 1);

    // ack in the last timeout cycle wins
    step(0, 1, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < TIMEOUT-1; k++) step(0, 1, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b1000, 4'b0000, 0);
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t5_owner", owner, 4'b1000); chk("t5_nonxm", nxm, 0);

    // reset during OWNED with rq held, then re-lock
    step(1, 1, 4'b0000, 4'b0000, 0);
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t6_owner0", owner, 4'b0000); chk("t6_idle", busy, 0);
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t6_wait", busy, 1);
    step(0, 1, 4'b0001, 4'b0000, 0);
    step(0, 1, 4'b0000, 4'b0000, 0);
    #1; chk("t6_relock", owner, 4'b0001);

    // random traffic
    for (int n = 0; n < 2500; n++) begin
      logic [NSLV-1:0] a, rr;
      a  = ($urandom_range(0, 6) == 0) ? NSLV'($urandom) : '0;
      rr = NSLV'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 15) != 0, a, rr,
           $urandom_range(0, 9) == 0);
    end
    step(0, 0, 4'b0000, 4'b0000, 0);
    repeat (4) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
